mybus_mem_responder: RTL and testbench

MYBUS_MEM_RESPONDER -- requirements
Module: mybus_mem_responder

---
 rtl/mybus_mem_responder_if.sv | 23 ++
 rtl/mybus_mem_responder.sv | 149 ++++++++++++++
 tb/tb_mybus_mem_responder.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mybus_mem_responder_if.sv
// Mybus handshake bundle: request channel (req/reqtag/reqcyc/reqack) and
// response channel (resp/respcyc/respack). Top is the responder end,
// Bottom is the requester end.
interface Mybus;
    logic [63:0] req;
    logic [12:0] reqtag;
    logic        reqcyc;
    logic        reqack;
    logic [63:0] resp;
    logic        respcyc;
    logic        respack;
    logic        bid;

    modport Top (
        input  req, reqtag, reqcyc, respack, bid,
        output reqack, resp, respcyc
    );

    modport Bottom (
        output req, reqtag, reqcyc, respack, bid,
        input  reqack, resp, respcyc
    );
endinterface

// File: rtl/mybus_mem_responder.sv
// Mybus memory responder: a line-oriented backing store (8 x 64-bit words per
// line) answering WRITE/MEMORY (header + 8 data beats) and READ/MEMORY
// (header, fixed latency, 8 response beats) requests.
// Optional feature: define MYBUS_RESP_BADTAG_CNT_EN to add the bad_tag_cnt
// port, a saturating count of accepted requests whose type is not MEMORY.
module mybus_mem_responder #(
    parameter int DEPTH_LINES = 256,
    parameter int RD_LATENCY  = 4
) (
    input  logic clk,
    input  logic reset,
    Mybus.Top    bus
`ifdef MYBUS_RESP_BADTAG_CNT_EN
    ,
    output logic [15:0] bad_tag_cnt
`endif
);
    localparam int LW = $clog2(DEPTH_LINES);
    localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CW-1:0] LAT_LAST = CW'(RD_LATENCY - 1);
    localparam logic [3:0]    TYPE_MEMORY = 4'h1;

    typedef enum logic [1:0] {IDLE, WR_DATA, RD_WAIT, RD_RESP} state_t;

    state_t        state, state_n;
    logic [LW-1:0] line, line_n;
    logic [2:0]    beat, beat_n;
    logic [CW-1:0] lat, lat_n;
    logic          reqack_q, reqack_n;
    logic          respcyc_q, respcyc_n;
    logic [63:0]   resp_q, resp_n;
    logic          wr_en;
    logic          bad_hit;
    logic          accept;

    // Backing store; deliberately never reset so data survives an abort.
    logic [63:0] mem [DEPTH_LINES*8];

    // A request beat is taken only in IDLE/WR_DATA and never while acking,
    // which limits acceptance to one beat every two cycles.
    assign accept = bus.reqcyc && !reqack_q && (state == IDLE || state == WR_DATA);

    assign bus.reqack  = reqack_q;
    assign bus.respcyc = respcyc_q;
    assign bus.resp    = resp_q;

    // Next-state and next-output decode.
    always_comb begin
        state_n   = state;
        line_n    = line;
        beat_n    = beat;
        lat_n     = lat;
        reqack_n  = 1'b0;
        respcyc_n = respcyc_q;
        resp_n    = resp_q;
        wr_en     = 1'b0;
        bad_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    reqack_n = 1'b1;
                    if (bus.reqtag[11:8] == TYPE_MEMORY) begin
                        line_n  = bus.req[6 +: LW];
                        beat_n  = 3'd0;
                        lat_n   = '0;
                        state_n = bus.reqtag[12] ? RD_WAIT : WR_DATA;
                    end else begin
                        bad_hit = 1'b1;
                    end
                end
            end
            WR_DATA: begin
                if (accept) begin
                    reqack_n = 1'b1;
                    wr_en    = 1'b1;
                    if (beat == 3'd7) begin
                        beat_n  = 3'd0;
                        state_n = IDLE;
                    end else begin
                        beat_n = beat + 3'd1;
                    end
                end
            end
            RD_WAIT: begin
                // Latency is counted from the reqack cycle itself.
                if (lat == LAT_LAST) begin
                    state_n   = RD_RESP;
                    respcyc_n = 1'b1;
                    resp_n    = mem[{line, 3'd0}];
                end else begin
                    lat_n = lat + CW'(1);
                end
            end
            RD_RESP: begin
                // Hold the current word until the requester takes it.
                if (bus.respack) begin
                    if (beat == 3'd7) begin
                        state_n   = IDLE;
                        respcyc_n = 1'b0;
                        resp_n    = '0;
                        beat_n    = 3'd0;
                    end else begin
                        beat_n = beat + 3'd1;
                        resp_n = mem[{line, beat + 3'd1}];
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counters and registered bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            line      <= '0;
            beat      <= 3'd0;
            lat       <= '0;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
        end else begin
            state     <= state_n;
            line      <= line_n;
            beat      <= beat_n;
            lat       <= lat_n;
            reqack_q  <= reqack_n;
            respcyc_q <= respcyc_n;
            resp_q    <= resp_n;
        end
    end

    // Store write port; reset suppresses the write but never clears contents.
    always_ff @(posedge clk) begin
        if (wr_en && !reset)
            mem[{line, beat}] <= bus.req;
    end

`ifdef MYBUS_RESP_BADTAG_CNT_EN
    // Saturating count of non-MEMORY requests.
    always_ff @(posedge clk) begin
        if (reset)
            bad_tag_cnt <= '0;
        else if (bad_hit && bad_tag_cnt != 16'hFFFF)
            bad_tag_cnt <= bad_tag_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mybus_mem_responder.sv
// Randomized bench for mybus_mem_responder with a transaction-level model:
// a word array mirrors the store, a queue holds the words each read must
// return, and a negedge monitor checks every meaningful output cycle.
module tb_mybus_mem_responder;
    localparam int DEPTH = 256;
    localparam int LAT   = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    Mybus bus();

`ifdef MYBUS_RESP_BADTAG_CNT_EN
    logic [15:0] bad_tag_cnt;
    mybus_mem_responder #(.DEPTH_LINES(DEPTH), .RD_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .bus(bus), .bad_tag_cnt(bad_tag_cnt));
`else
    mybus_mem_responder #(.DEPTH_LINES(DEPTH), .RD_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .bus(bus));
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [63:0] model [DEPTH*8];
    logic [63:0] expq [$];
    int  rd_beat = 0;
    int  rd_ack_cyc = -100;
    int  stall_beat = -1;
    int  stall_left = 0;
    bit  rnd_ack = 1'b0;
    int  ack_pulses = 0;
    bit  prev_ack = 1'b0;
    bit  prev_respcyc = 1'b0;
    bit  lit_en = 1'b0;
    bit  stall_chk = 1'b0;
    logic [63:0] lit [8];
    int  bad_model = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: handshake rules, read latency and response data vs model.
    always @(negedge clk) begin
        if (reset) begin
            prev_ack     = 1'b0;
            prev_respcyc = 1'b0;
        end else begin
            if (bus.reqack) begin
                ack_pulses++;
                check("reqack_width", 64'(prev_ack), 64'd0);
                check("ack_in_resp", 64'(bus.respcyc), 64'd0);
                if (cyc != rd_ack_cyc)
                    check("ack_while_busy", 64'(expq.size()), 64'd0);
            end
            if (bus.respcyc) begin
                if (!prev_respcyc)
                    check("rd_latency", 64'(cyc - rd_ack_cyc), 64'(LAT));
                if (expq.size() == 0) begin
                    check("spurious_respcyc", 64'(bus.respcyc), 64'd0);
                end else begin
                    check("resp_data", bus.resp, expq[0]);
                    if (lit_en)
                        check("resp_literal", bus.resp, lit[rd_beat]);
                    if (stall_chk && rd_beat == 3 && !bus.respack)
                        check("stall_hold", bus.resp, 64'hA3);
                    if (bus.respack) begin
                        void'(expq.pop_front());
                        rd_beat = (rd_beat + 1) % 8;
                    end
                end
            end else if (expq.size() > 0 && cyc - rd_ack_cyc >= LAT) begin
                check("respcyc_missing", 64'(bus.respcyc), 64'd1);
            end
            prev_ack     = bus.reqack;
            prev_respcyc = bus.respcyc;
        end
    end

    // Requester response acceptance: always, random, or a scripted stall.
    initial begin
        bus.respack = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (stall_left > 0 && bus.respcyc && rd_beat == stall_beat) begin
                bus.respack = 1'b0;
                stall_left--;
            end else begin
                bus.respack = rnd_ack ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    task automatic send(input logic [12:0] tag, input logic [63:0] data, output bit ok);
        ok = 1'b0;
        bus.reqcyc = 1'b1;
        bus.reqtag = tag;
        bus.req    = data;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (bus.reqack) begin
                ok = 1'b1;
                break;
            end
        end
        bus.reqcyc = 1'b0;
        if (!ok) check("ack_timeout", 64'(bus.reqack), 64'd1);
    endtask

    function automatic int line_of(input logic [63:0] addr);
        return int'((addr >> 6) % DEPTH);
    endfunction

    task automatic do_write(input logic [63:0] addr, input logic [63:0] d [8], input int nb);
        bit ok;
        int ln;
        ln = line_of(addr);
        send({1'b0, 4'h1, 8'($urandom)}, addr, ok);
        if (ok) begin
            for (int b = 0; b < nb; b++) begin
                send(13'($urandom), d[b], ok);
                if (!ok) break;
                model[ln*8 + b] = d[b];
            end
        end
    endtask

    task automatic do_read(input logic [63:0] addr);
        bit ok;
        int ln;
        ln = line_of(addr);
        send({1'b1, 4'h1, 8'($urandom)}, addr, ok);
        if (ok) begin
            rd_ack_cyc = cyc;
            rd_beat    = 0;
            for (int b = 0; b < 8; b++) expq.push_back(model[ln*8 + b]);
        end
    endtask

    task automatic do_bad(input logic [63:0] addr, input logic [12:0] tag);
        bit ok;
        send(tag, addr, ok);
        if (ok && bad_model < 16'hFFFF) bad_model++;
    endtask

    task automatic wait_rd();
        for (int i = 0; i < 400 && expq.size() > 0; i++) begin
            @(posedge clk); #2;
        end
        if (expq.size() > 0) begin
            check("rd_timeout", 64'(expq.size()), 64'd0);
            expq.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.reqcyc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        expq.delete();
        rd_beat    = 0;
        rd_ack_cyc = -100;
        stall_left = 0;
        bad_model  = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] da [8];
        logic [63:0] db [8];
        logic [63:0] dr [8];
        int pool [8];
        int ack0;
        bus.reqcyc = 1'b0;
        bus.req    = '0;
        bus.reqtag = '0;
        bus.bid    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            da[i] = 64'hA0 + 64'(i);
            db[i] = 64'hB0 + 64'(i);
        end

        // Reset then idle: outputs quiet.
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        check("rst_reqack", 64'(bus.reqack), 64'd0);
        check("rst_respcyc", 64'(bus.respcyc), 64'd0);
        check("rst_resp", bus.resp, 64'd0);
`ifdef MYBUS_RESP_BADTAG_CNT_EN
        check("rst_badcnt", 64'(bad_tag_cnt), 64'd0);
`endif

        // Write line 0x40 then read it back.
        ack0 = ack_pulses;
        do_write(64'h1000, da, 8);
        @(negedge clk); #1;
        check("wr_ack_pulses", 64'(ack_pulses - ack0), 64'd9);
        lit    = da;
        lit_en = 1'b1;
        do_read(64'h1000);
        wait_rd();

        // Stall 10 cycles on beat 3.
        stall_beat = 3;
        stall_left = 10;
        stall_chk  = 1'b1;
        do_read(64'h1000);
        wait_rd();
        stall_chk = 1'b0;
        lit_en    = 1'b0;

        // PORT-type request: acked, no response.
        do_bad(64'h1000, 13'h1300);
        repeat (8) @(posedge clk);
        #1;
`ifdef MYBUS_RESP_BADTAG_CNT_EN
        check("badcnt_one", 64'(bad_tag_cnt), 64'd1);
`endif
        // Request issued during RD_RESP must wait until IDLE.
        stall_beat = 0;
        stall_left = 20;
        do_read(64'h1000);
        for (int i = 0; i < 8; i++) dr[i] = 64'hC0 + 64'(i);
        do_write(64'h2000, dr, 8);
        wait_rd();
        do_read(64'h2000);
        wait_rd();

        // Address beyond the store aliases line 0x40.
        lit    = da;
        lit_en = 1'b1;
        do_read(64'h1000 + 64'(DEPTH * 64));
        wait_rd();

        // Reset during write beat 4: beats 0-3 new, 4-7 old.
        do_write(64'h1000, db, 4);
        do_reset();
        for (int i = 0; i < 8; i++) lit[i] = (i < 4) ? db[i] : da[i];
        do_read(64'h1000);
        wait_rd();
        lit_en = 1'b0;

        // Randomized traffic with random respack.
        rnd_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pool[i] = $urandom_range(0, DEPTH - 1);
            for (int b = 0; b < 8; b++) dr[b] = {$urandom(), $urandom()};
            do_write({32'($urandom), 18'($urandom), 8'(pool[i]), 6'($urandom)}, dr, 8);
        end
        for (int n = 0; n < 60; n++) begin
            int r, p, ty;
            logic [63:0] addr;
            r = $urandom_range(0, 9);
            p = $urandom_range(0, 7);
            addr = {32'($urandom), 18'($urandom), 8'(pool[p]), 6'($urandom)};
            if (r < 4) begin
                for (int b = 0; b < 8; b++) dr[b] = {$urandom(), $urandom()};
                do_write(addr, dr, 8);
            end else if (r < 8) begin
                do_read(addr);
                wait_rd();
            end else begin
                ty = $urandom_range(0, 14);
                if (ty >= 1) ty++;
                do_bad(addr, {1'($urandom), 4'(ty), 8'($urandom)});
            end
        end
        wait_rd();
`ifdef MYBUS_RESP_BADTAG_CNT_EN
        check("badcnt_final", 64'(bad_tag_cnt), 64'(bad_model));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
